keyed_dup_fsm: RTL and testbench

- Parametrised key-locked sequencing FSM for the obfuscation benchmark set.
- Walks a ring of N_STATES control states and drives a decoded output pattern from the current state.
- At a configurable lock point, a multi-bit key input selects either the genuine successor state or a duplicate state.
- The duplicate state is functionally identical until a visit counter reaches TRIG_LIMIT. From then on it suppresses its outputs.
- Successor to the single-bit, fixed-FSM keyed benchmarks: key width, ring depth, lock position and trigger threshold are all parameters.

---
 rtl/keyed_dup_fsm_if.sv | 32 +++
 rtl/keyed_dup_fsm.sv | 122 ++++++++++++
 tb/tb_keyed_dup_fsm.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/keyed_dup_fsm_if.sv
// rtl/keyed_dup_fsm_if.sv - condition/key inputs and decoded outputs of keyed_dup_fsm
// Purpose: bundles the non-clock signals of keyed_dup_fsm.
// Signals:
//   x        IN_W   advance conditions      (master -> slave)
//   keyinput KEY_W  key                     (master -> slave)
//   y        OUT_W  decoded control outputs (slave -> master)
//   state_o  SW     current state code      (slave -> master)
interface keyed_dup_fsm_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8,
    parameter int KEY_W = 4,
    parameter int SW    = 4
);
    logic [IN_W-1:0]  x;
    logic [KEY_W-1:0] keyinput;
    logic [OUT_W-1:0] y;
    logic [SW-1:0]    state_o;

    modport master (
        output x,
        output keyinput,
        input  y,
        input  state_o
    );

    modport slave (
        input  x,
        input  keyinput,
        output y,
        output state_o
    );
endinterface

// File: rtl/keyed_dup_fsm.sv
// rtl/keyed_dup_fsm.sv - key-locked ring FSM with a counter-triggered duplicate state
// Purpose: walks a ring S0..S(N_STATES-1); the advance out of S(LOCK_STATE-1)
// goes to S(LOCK_STATE) with the right key or to a duplicate state S_dup
// otherwise. S_dup mimics S(LOCK_STATE) until it has been entered TRIG_LIMIT
// times, after which its outputs read zero.
// Ports:
//   clk  in  clock, state updates on the falling edge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of keyed_dup_fsm_if (x, keyinput in; y, state_o out)
module keyed_dup_fsm #(
    parameter int               N_STATES   = 8,
    parameter int               IN_W       = 4,
    parameter int               OUT_W      = 8,
    parameter int               KEY_W      = 4,
    parameter logic [KEY_W-1:0] KEY_VAL    = 4'hA,
    parameter int               LOCK_STATE = 5,
    parameter int               TRIG_LIMIT = 5,
    parameter int               CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    keyed_dup_fsm_if.slave    bus
);
    localparam int SW = $clog2(N_STATES + 1);

    localparam logic [SW-1:0]    S_ZERO  = '0;
    localparam logic [SW-1:0]    S_PRE   = SW'(LOCK_STATE - 1);
    localparam logic [SW-1:0]    S_LOCK  = SW'(LOCK_STATE);
    localparam logic [SW-1:0]    S_LAST  = SW'(N_STATES - 1);
    localparam logic [SW-1:0]    S_DUP   = SW'(N_STATES);
    localparam logic [SW-1:0]    S_AFTER = SW'((LOCK_STATE + 1) % N_STATES);
    localparam logic [CNT_W-1:0] TRIG_C  = CNT_W'(TRIG_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Class of the current state code; the ring itself is indexed numerically.
    typedef enum logic [1:0] {
        K_RING,
        K_PRE,
        K_DUP,
        K_ILLEGAL
    } kind_t;

    logic [SW-1:0]    r_state;
    logic [CNT_W-1:0] r_count;

    kind_t            w_kind;
    logic [SW-1:0]    w_next;
    logic             w_cnt_inc;
    logic             w_adv;
    logic [OUT_W-1:0] w_y;
    logic [OUT_W-1:0] w_ring_y;
    logic             w_ring_adv;
    logic             w_dup_adv;

    always_comb begin
        if (r_state == S_PRE)
            w_kind = K_PRE;
        else if (r_state < S_DUP)
            w_kind = K_RING;
        else if (r_state == S_DUP)
            w_kind = K_DUP;
        else
            w_kind = K_ILLEGAL;
    end

    // Bit-select by shift-and-mask keeps the index arithmetic in int.
    assign w_ring_y   = OUT_W'(1) << (int'(r_state) % OUT_W);
    assign w_ring_adv = |(bus.x & (IN_W'(1) << (int'(r_state) % IN_W)));
    assign w_dup_adv  = |(bus.x & (IN_W'(1) << (LOCK_STATE % IN_W)));

    always_comb begin
        w_next    = r_state;
        w_cnt_inc = 1'b0;
        w_adv     = 1'b0;
        w_y       = '0;
        case (w_kind)
            K_RING: begin
                w_y   = w_ring_y;
                w_adv = w_ring_adv;
                if (w_adv)
                    w_next = (r_state == S_LAST) ? S_ZERO : r_state + SW'(1);
            end
            K_PRE: begin
                w_y   = w_ring_y;
                w_adv = w_ring_adv;
                // The key only matters on the edge that leaves the lock predecessor.
                if (w_adv) begin
                    if (bus.keyinput == KEY_VAL) begin
                        w_next = S_LOCK;
                    end else begin
                        w_next    = S_DUP;
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            K_DUP: begin
                w_y   = (r_count >= TRIG_C) ? '0 : OUT_W'(1) << (LOCK_STATE % OUT_W);
                w_adv = w_dup_adv;
                if (w_adv)
                    w_next = S_AFTER;
            end
            default: begin
                w_y    = '0;
                w_next = S_ZERO;
            end
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ZERO;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_cnt_inc && (r_count != CNT_MAX))
                r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.y       = w_y;
    assign bus.state_o = r_state;
endmodule

// File: tb/tb_keyed_dup_fsm.sv
// tb/tb_keyed_dup_fsm.sv - scoreboard bench for keyed_dup_fsm
module tb_keyed_dup_fsm;
    logic clk;
    logic rst;

    keyed_dup_fsm_if #(.IN_W(4), .OUT_W(8), .KEY_W(4), .SW(4)) bus ();

    keyed_dup_fsm #(
        .N_STATES(8), .IN_W(4), .OUT_W(8), .KEY_W(4), .KEY_VAL(4'hA),
        .LOCK_STATE(5), .TRIG_LIMIT(5), .CNT_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] st;
        logic [7:0] y;
    } exp_t;
    exp_t sb[$];

    // Reference: ring of 8, lock at 5 (predecessor 4), dup code 8, trigger 5.
    int m_state;
    int m_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_y();
        if (m_state == 8)
            return (m_count >= 5) ? 8'h00 : 8'h20;
        return 8'(1 << m_state);
    endfunction

    task automatic model_step(input logic [3:0] xv, input logic [3:0] kv);
        int b;
        b = (m_state == 8) ? 1 : (m_state % 4);
        if (xv[b]) begin
            if (m_state == 4) begin
                if (kv == 4'hA) begin
                    m_state = 5;
                end else begin
                    m_state = 8;
                    if (m_count < 255) m_count++;
                end
            end else if (m_state == 8) begin
                m_state = 6;
            end else begin
                m_state = (m_state + 1) % 8;
            end
        end
    endtask

    // Called just after a rising edge; result is sampled 2 units after the falling edge.
    task automatic step(input logic [3:0] xv, input logic [3:0] kv);
        exp_t e;
        bus.x        = xv;
        bus.keyinput = kv;
        model_step(xv, kv);
        e.st = 4'(m_state);
        e.y  = model_y();
        sb.push_back(e);
        @(negedge clk);
        #2;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("state", 32'(bus.state_o), 32'(e.st));
            check("y", 32'(bus.y), 32'(e.y));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        check("rst_state", 32'(bus.state_o), 32'h0);
        check("rst_y", 32'(bus.y), 32'h01);
        m_state = 0;
        m_count = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.x        = '0;
        bus.keyinput = '0;
        m_state      = 0;
        m_count      = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(bus.state_o), 32'h0);
        check("reset_y", 32'(bus.y), 32'h01);
        rst = 1'b0;

        // Reset asserted between edges takes effect at once.
        step(4'hF, 4'hA);
        step(4'hF, 4'hA);
        #1;
        async_reset();

        // Correct-key walk around the whole ring.
        for (int i = 0; i < 8; i++) begin
            step(4'hF, 4'hA);
            check("walk_no_dup", 32'(bus.state_o != 4'd8), 32'h1);
            if (i == 4) check("walk_s5_y", 32'(bus.y), 32'h20);
        end
        check("walk_end", 32'(bus.state_o), 32'h0);

        // Hold in S3 while x[3]=0.
        for (int i = 0; i < 3; i++) step(4'hF, 4'hA);
        for (int i = 0; i < 10; i++) step(4'h7, 4'hA);
        check("hold_state", 32'(bus.state_o), 32'h3);
        check("hold_y", 32'(bus.y), 32'h08);
        step(4'h8, 4'hA);
        check("hold_release", 32'(bus.state_o), 32'h4);

        // Wrong key: five loops through S_dup, suppression from visit 5.
        for (int loop = 1; loop <= 5; loop++) begin
            step(4'hF, 4'h3);
            check("dup_state", 32'(bus.state_o), 32'h8);
            check("dup_y", 32'(bus.y), (loop < 5) ? 32'h20 : 32'h00);
            step(4'hF, 4'h3);
            check("after_dup_state", 32'(bus.state_o), 32'h6);
            check("after_dup_y", 32'(bus.y), 32'h40);
            for (int j = 0; j < 6; j++) step(4'hF, 4'h3);
        end

        // Dup state holds while x[1]=0.
        step(4'hF, 4'h3);
        step(4'hD, 4'h3);
        check("dup_hold", 32'(bus.state_o), 32'h8);
        check("dup_hold_y", 32'(bus.y), 32'h00);

        // Reset while in S_dup clears the visit count.
        #1;
        async_reset();
        for (int i = 0; i < 5; i++) step(4'hF, 4'h3);
        check("post_rst_dup", 32'(bus.state_o), 32'h8);
        check("post_rst_y", 32'(bus.y), 32'h20);

        // Key wrong earlier in the ring but right at the S4 advance.
        for (int i = 0; i < 5; i++) step(4'hF, 4'h3);
        check("key_at_s2", 32'(bus.state_o), 32'h2);
        step(4'hF, 4'h3);
        step(4'hF, 4'h3);
        check("key_at_s4", 32'(bus.state_o), 32'h4);
        step(4'hF, 4'hA);
        check("key_late_ok", 32'(bus.state_o), 32'h5);
        check("key_late_y", 32'(bus.y), 32'h20);
        // Count must still be 1: the next wrong-key visit is the second and clean.
        for (int i = 0; i < 7; i++) step(4'hF, 4'h3);
        step(4'hF, 4'h3);
        check("count_kept", 32'(bus.state_o), 32'h8);
        check("count_kept_y", 32'(bus.y), 32'h20);

        if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
